// File: rtl/seq_alu_core.sv
// Single-clock sequential ALU: operand registers, start/busy/done handshake,
// iterative (or barrel) shifter and shift-add multiplier, registered F/FR.
module seq_alu_core #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          FAST_SHIFT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic [3:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic [3:0]       FR,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_FIN} state_e;

  state_e           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] wa_q, wb_q, acc_q;
  logic [CW-1:0]    cnt_q;

  logic [SW-1:0]    shamt_c;
  logic [WIDTH-1:0] fast_sh_c;
  logic             is_shift_c;
  logic [WIDTH:0]   sum_c, diff_c;
  logic [WIDTH-1:0] res_c;
  logic             of_c, cf_c;

  // Barrel shift of the live A register, used when the shift finishes in one step.
  always_comb begin
    shamt_c    = b_q[SW-1:0];
    is_shift_c = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    case (op)
      OP_SLL:  fast_sh_c = a_q << shamt_c;
      OP_SRL:  fast_sh_c = a_q >> shamt_c;
      OP_SRA:  fast_sh_c = WIDTH'($signed(a_q) >>> shamt_c);
      default: fast_sh_c = a_q;
    endcase
  end

  // Result and arithmetic flags from the working registers, consumed in FIN.
  always_comb begin
    sum_c  = {1'b0, wa_q} + {1'b0, wb_q};
    diff_c = {1'b0, wa_q} - {1'b0, wb_q};
    of_c   = 1'b0;
    cf_c   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_c = sum_c[WIDTH-1:0];
        of_c  = (wa_q[WIDTH-1] == wb_q[WIDTH-1]) && (sum_c[WIDTH-1] != wa_q[WIDTH-1]);
        cf_c  = sum_c[WIDTH];
      end
      OP_SUB: begin
        res_c = diff_c[WIDTH-1:0];
        of_c  = (wa_q[WIDTH-1] != wb_q[WIDTH-1]) && (diff_c[WIDTH-1] != wa_q[WIDTH-1]);
        cf_c  = diff_c[WIDTH];
      end
      OP_AND:  res_c = wa_q & wb_q;
      OP_OR:   res_c = wa_q | wb_q;
      OP_XOR:  res_c = wa_q ^ wb_q;
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(wa_q) < $signed(wb_q))};
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (wa_q < wb_q)};
      OP_SLL, OP_SRL, OP_SRA, OP_MUL: res_c = acc_q;
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      F       <= '0;
      FR      <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      done <= 1'b0;
      // Operand loads are frozen for the whole operation, FIN included.
      if (!busy && ld_a) a_q <= din;
      if (!busy && ld_b) b_q <= din;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q <= op;
            wa_q <= a_q;
            wb_q <= b_q;
            busy <= 1'b1;
            if (is_shift_c) begin
              if (FAST_SHIFT || (shamt_c == '0)) begin
                acc_q   <= fast_sh_c;
                state_q <= S_FIN;
              end else begin
                acc_q   <= a_q;
                cnt_q   <= CW'(shamt_c);
                state_q <= S_SHIFT;
              end
            end else if (op == OP_MUL) begin
              acc_q   <= '0;
              cnt_q   <= CW'(WIDTH);
              state_q <= S_MUL;
            end else begin
              state_q <= S_FIN;
            end
          end
        end
        S_SHIFT: begin
          case (op_q)
            OP_SLL:  acc_q <= {acc_q[WIDTH-2:0], 1'b0};
            OP_SRL:  acc_q <= {1'b0, acc_q[WIDTH-1:1]};
            default: acc_q <= {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
          endcase
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_FIN;
        end
        S_MUL: begin
          if (wb_q[0]) acc_q <= acc_q + wa_q;
          wa_q  <= {wa_q[WIDTH-2:0], 1'b0};
          wb_q  <= {1'b0, wb_q[WIDTH-1:1]};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_FIN;
        end
        default: begin
          F       <= res_c;
          FR      <= {(res_c == '0), res_c[WIDTH-1], of_c, cf_c};
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
